// File: rtl/program_counter_pkg.sv
// Shared Y86-32 opcode constants, default address width and the instruction-length decode.
package program_counter_pkg;

  localparam int DATA_WID = 32;

  localparam logic [3:0] _HALT  = 4'h0;
  localparam logic [3:0] _NOP   = 4'h1;
  localparam logic [3:0] _RRMOV = 4'h2;
  localparam logic [3:0] _IRMOV = 4'h3;
  localparam logic [3:0] _RMMOV = 4'h4;
  localparam logic [3:0] _MRMOV = 4'h5;
  localparam logic [3:0] _OP    = 4'h6;
  localparam logic [3:0] _JXX   = 4'h7;
  localparam logic [3:0] _CALL  = 4'h8;
  localparam logic [3:0] _RET   = 4'h9;
  localparam logic [3:0] _PUSH  = 4'hA;
  localparam logic [3:0] _POP   = 4'hB;

  // Codes C-F are undefined; they advance by one byte like a single-byte opcode.
  function automatic logic [2:0] instr_len(input logic [3:0] icode);
    case (icode)
      _RRMOV, _OP, _PUSH, _POP: instr_len = 3'd2;
      _IRMOV, _RMMOV, _MRMOV:   instr_len = 3'd6;
      _JXX, _CALL:              instr_len = 3'd5;
      default:                  instr_len = 3'd1;
    endcase
  endfunction

  function automatic logic is_invalid(input logic [3:0] icode);
    is_invalid = (icode >= 4'hC);
  endfunction

endpackage

// File: rtl/program_counter_if.sv
// Fetch/execute-side signals of the PC stage: instruction info in, PC and fall-through out.
interface program_counter_if #(parameter int DATA_WID = 32);
  logic [3:0]          icode;
  logic                Cnd;
  logic [DATA_WID-1:0] valC;
  logic [DATA_WID-1:0] valM;
  logic [DATA_WID-1:0] valP;
  logic [DATA_WID-1:0] PC;

  modport master (output icode, Cnd, valC, valM, input valP, PC);
  modport slave  (input icode, Cnd, valC, valM, output valP, PC);
endinterface

// File: rtl/program_counter_pc_increment.sv
// Fall-through address: current PC plus the length of the instruction at that PC.
module pc_increment
  import program_counter_pkg::*;
#(
  parameter int DATA_WID = 32
) (
  input  logic [3:0]          icode,
  input  logic [DATA_WID-1:0] PC,
  output logic [DATA_WID-1:0] valP
);

  // Modular add; wrap past the top of the address space is intentional.
  assign valP = PC + DATA_WID'(instr_len(icode));

endmodule

// File: rtl/program_counter.sv
// Y86 PC register with next-PC select (call/taken jump/return/hold/fall-through).
module program_counter #(
  parameter int DATA_WID = program_counter_pkg::DATA_WID
) (
  input  logic              CLK,
  input  logic              RST,
  program_counter_if.slave  pc_bus
);
  import program_counter_pkg::*;

  logic [DATA_WID-1:0] pc_q;
  logic [DATA_WID-1:0] val_p;
  logic [DATA_WID-1:0] pc_next;

  pc_increment #(.DATA_WID(DATA_WID)) u_inc (
    .icode (pc_bus.icode),
    .PC    (pc_q),
    .valP  (val_p)
  );

  always_comb begin
    pc_next = val_p;
    if (pc_bus.icode == _CALL)
      pc_next = pc_bus.valC;
    else if (pc_bus.icode == _JXX && pc_bus.Cnd)
      pc_next = pc_bus.valC;
    else if (pc_bus.icode == _RET)
      pc_next = pc_bus.valM;
    else if (pc_bus.icode == _HALT || is_invalid(pc_bus.icode))
      pc_next = pc_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_q <= '0;
    else     pc_q <= pc_next;
  end

  assign pc_bus.PC   = pc_q;
  assign pc_bus.valP = val_p;

endmodule

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter with hand-computed PC/valP expectations.
module tb_program_counter;
  import program_counter_pkg::*;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_bad;

  program_counter_if #(.DATA_WID(32)) bus ();

  program_counter #(.DATA_WID(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .pc_bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge, well clear of the active edge.
  task automatic drive(input logic [3:0] ic, input logic c, input logic [31:0] vc,
                       input logic [31:0] vm);
    @(negedge CLK);
    bus.icode = ic;
    bus.Cnd   = c;
    bus.valC  = vc;
    bus.valM  = vm;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b0;
    bus.icode = _NOP;
    bus.Cnd   = 1'b0;
    bus.valC  = 32'h0;
    bus.valM  = 32'h0;

    // Async reset takes effect before any clock edge (first posedge at t=5).
    #2 RST = 1'b1;
    #1;
    chk("reset_pc_async", bus.PC, 32'd0);
    chk("reset_valp_nop", bus.valP, 32'd1);

    drive(_RMMOV, 1'b1, 32'h55, 32'h66);
    RST = 1'b0;
    chk("rmmov_valp", bus.valP, 32'd6);
    tick();
    chk("rmmov_pc", bus.PC, 32'd6);

    drive(_IRMOV, 1'b0, 32'h0, 32'h0);
    chk("irmov_valp", bus.valP, 32'd12);
    tick();
    chk("irmov_pc", bus.PC, 32'd12);

    drive(_OP, 1'b1, 32'd99, 32'd77);
    tick();
    chk("op_pc", bus.PC, 32'd14);

    drive(_JXX, 1'b1, 32'd64, 32'd0);
    tick();
    chk("jxx_taken_pc", bus.PC, 32'd64);

    drive(_JXX, 1'b0, 32'd80, 32'd0);
    chk("jxx_nt_valp", bus.valP, 32'd69);
    tick();
    chk("jxx_nt_pc", bus.PC, 32'd69);

    drive(_CALL, 1'b0, 32'd8, 32'd200);
    tick();
    chk("call_pc", bus.PC, 32'd8);

    drive(_RET, 1'b0, 32'd300, 32'd16);
    tick();
    chk("ret_pc", bus.PC, 32'd16);

    drive(_HALT, 1'b1, 32'd500, 32'd600);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_pc", bus.PC, 32'd16);
      chk("halt_valp", bus.valP, 32'd17);
    end

    drive(_POP, 1'b1, 32'd700, 32'd800);
    tick();
    chk("pop_pc", bus.PC, 32'd18);

    drive(_PUSH, 1'b0, 32'd0, 32'd0);
    tick();
    chk("push_pc", bus.PC, 32'd20);

    drive(_MRMOV, 1'b0, 32'd0, 32'd0);
    tick();
    chk("mrmov_pc", bus.PC, 32'd26);

    drive(_RRMOV, 1'b1, 32'd0, 32'd0);
    tick();
    chk("rrmov_pc", bus.PC, 32'd28);

    // Invalid opcode holds, valP still PC+1.
    drive(4'hD, 1'b1, 32'd900, 32'd901);
    chk("invalid_valp", bus.valP, 32'd29);
    tick();
    chk("invalid_pc", bus.PC, 32'd28);

    drive(_CALL, 1'b0, 32'hFFFF_FFFE, 32'd0);
    tick();
    chk("wrap_setup_pc", bus.PC, 32'hFFFF_FFFE);

    drive(_IRMOV, 1'b0, 32'd0, 32'd0);
    chk("wrap_valp", bus.valP, 32'd4);
    tick();
    chk("wrap_pc", bus.PC, 32'd4);

    drive(_CALL, 1'b0, 32'd64, 32'd0);
    tick();
    chk("pre_rst_pc", bus.PC, 32'd64);

    // Mid-cycle reset, held across an edge with a CALL pending.
    drive(_CALL, 1'b0, 32'd100, 32'd0);
    RST = 1'b1;
    #1;
    chk("midrst_pc", bus.PC, 32'd0);
    chk("midrst_valp_call", bus.valP, 32'd5);
    tick();
    chk("midrst_hold_pc", bus.PC, 32'd0);

    drive(_NOP, 1'b0, 32'd100, 32'd0);
    RST = 1'b0;
    chk("post_rst_valp", bus.valP, 32'd1);
    tick();
    chk("post_rst_pc", bus.PC, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
